// File: rtl/mux_rr_pipe_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants and helpers for the operand-routing multiplexer.
//   MODE_SEL / MODE_RR : values of the run-time mode input
//   wrap_add()         : modular add used for round-robin pointer arithmetic
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic MODE_SEL = 1'b0;   // explicit channel select
   localparam logic MODE_RR  = 1'b1;   // round-robin arbitration

   // (base + off) mod n, assuming base < n and off < n, so a single
   // conditional subtract is enough and no divider is inferred.
   function automatic int wrap_add(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/mux_rr_pipe_if.sv
// ---------------------------------------------------------------------------
// mux_rr_pipe_if
// Groups the input channels, mode/select controls and output handshake of
// mux_rr_pipe.
//   in_data   NUM_CH*WIDTH  channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid  NUM_CH        per-channel valid
//   in_ready  NUM_CH        per-channel accept (one-hot or zero)
//   mode      1             0 = select, 1 = round-robin
//   sel       SEL_W         channel select (select mode)
//   out_data  WIDTH         registered output word
//   out_ch    SEL_W         channel id of out_data
//   out_valid 1             output word valid
//   out_ready 1             downstream accept
// master: the side that drives the channels and consumes the output.
// slave : the multiplexer itself.
// ---------------------------------------------------------------------------
interface mux_rr_pipe_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 4
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [NUM_CH*WIDTH-1:0] in_data;
   logic [NUM_CH-1:0]       in_valid;
   logic [NUM_CH-1:0]       in_ready;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_ch;
   logic                    out_valid;
   logic                    out_ready;

   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_ch, out_valid
   );

   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_ch, out_valid
   );
endinterface

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational priority-from-pointer arbiter. Searches req starting
// at ptr, then ptr+1, ... wrapping mod NUM_CH, and reports the first hit.
//   req       in  NUM_CH  request vector
//   ptr       in  SEL_W   highest-priority channel this cycle (< NUM_CH)
//   gnt_valid out 1       some request was found
//   gnt_id    out SEL_W   granted channel (0 when gnt_valid=0)
// ---------------------------------------------------------------------------
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_CH = 4
) (
   input  logic [NUM_CH-1:0]         req,
   input  logic [$clog2(NUM_CH)-1:0] ptr,
   output logic                      gnt_valid,
   output logic [$clog2(NUM_CH)-1:0] gnt_id
);
   localparam int SEL_W = $clog2(NUM_CH);

   // Walk offsets from farthest to nearest so the nearest requester,
   // assigned last, wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_id    = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (req[wrap_add(int'(ptr), k, NUM_CH)]) begin
            gnt_valid = 1'b1;
            gnt_id    = SEL_W'(wrap_add(int'(ptr), k, NUM_CH));
         end
      end
   end
endmodule

// File: rtl/mux_rr_pipe.sv
// ---------------------------------------------------------------------------
// mux_rr_pipe
// N:1 datapath multiplexer with a single registered output stage and
// valid/ready on every input and on the output. Select mode routes the
// channel named by sel; round-robin mode arbitrates among valid channels.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    mux_rr_pipe_if.slave (channels, mode/sel, output handshake)
// Latency 1 cycle; throughput 1 word/cycle while out_ready=1.
// ---------------------------------------------------------------------------
module mux_rr_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   mux_rr_pipe_if.slave  bus
);
   localparam int SEL_W = $clog2(NUM_CH);

   logic [WIDTH-1:0] ch_data [NUM_CH];

   logic [WIDTH-1:0] out_data_reg;
   logic [SEL_W-1:0] out_ch_reg;
   logic             out_valid_reg;
   logic [SEL_W-1:0] rr_ptr_reg;
   logic [SEL_W-1:0] rr_ptr_next;

   logic             rr_gnt_valid;
   logic [SEL_W-1:0] rr_gnt_id;
   logic             sel_gnt_valid;
   logic             gnt_valid;
   logic [SEL_W-1:0] gnt_id;
   logic [WIDTH-1:0] gnt_data;
   logic             load;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_split
         assign ch_data[gi] = bus.in_data[gi*WIDTH +: WIDTH];
      end
   endgenerate

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .req       (bus.in_valid),
      .ptr       (rr_ptr_reg),
      .gnt_valid (rr_gnt_valid),
      .gnt_id    (rr_gnt_id)
   );

   // Select path: compare sel against each legal channel id instead of
   // indexing in_valid with sel, so an out-of-range sel simply matches
   // nothing and yields no grant.
   always_comb begin
      sel_gnt_valid = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if ((bus.sel == SEL_W'(i)) && bus.in_valid[i]) begin
            sel_gnt_valid = 1'b1;
         end
      end
   end

   assign gnt_valid = (bus.mode == MODE_RR) ? rr_gnt_valid : sel_gnt_valid;
   assign gnt_id    = (bus.mode == MODE_RR) ? rr_gnt_id    : bus.sel;

   // Single-entry register: accept whenever it is empty or being drained.
   assign load = !out_valid_reg || bus.out_ready;

   // in_ready is forced low while reset is asserted, even though the
   // cleared register would otherwise report load=1.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
         assign bus.in_ready[gi] = rst_n && load && gnt_valid
                                   && (gnt_id == SEL_W'(gi));
      end
   endgenerate

   // Data mux keyed on the grant id; unmatched ids fall through to zero,
   // though they are never loaded because gnt_valid is low for them.
   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_id == SEL_W'(i)) begin
            gnt_data = ch_data[i];
         end
      end
   end

   assign rr_ptr_next = SEL_W'(wrap_add(int'(gnt_id), 1, NUM_CH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         out_valid_reg <= 1'b0;
         rr_ptr_reg    <= '0;
      end else if (load) begin
         if (gnt_valid) begin
            out_data_reg  <= gnt_data;
            out_ch_reg    <= gnt_id;
            out_valid_reg <= 1'b1;
            // Only round-robin transfers move the fairness pointer.
            if (bus.mode == MODE_RR) begin
               rr_ptr_reg <= rr_ptr_next;
            end
         end else begin
            // Empty load: drop valid but keep the last word and id visible.
            out_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.out_data  = out_data_reg;
   assign bus.out_ch    = out_ch_reg;
   assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_mux_rr_pipe.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_pipe
// Directed bench for mux_rr_pipe. Two instances: NUM_CH=4 for the main
// scenarios and NUM_CH=3 for out-of-range select and mid-stall reset.
// Stimulus pushes expected {ch,data} words into per-DUT queues; monitors
// pop and compare on every output handshake.
// ---------------------------------------------------------------------------
module tb_mux_rr_pipe;
   import alu_pkg::*;

   logic clk;
   logic rst_n;
   logic rst3_n;

   int checks = 0;
   int errors = 0;

   logic [17:0] q4[$];
   logic [17:0] q3[$];
   logic [17:0] exp4;
   logic [17:0] exp3;

   mux_rr_pipe_if #(.WIDTH(16), .NUM_CH(4)) bus4 ();
   mux_rr_pipe_if #(.WIDTH(16), .NUM_CH(3)) bus3 ();

   mux_rr_pipe #(.WIDTH(16), .NUM_CH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4)
   );

   mux_rr_pipe #(.WIDTH(16), .NUM_CH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst3_n),
      .bus   (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic set4(input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
      bus4.in_valid = v;
      bus4.in_data  = {d3, d2, d1, d0};
   endtask

   // Inputs are already applied (posedge+1); check at negedge, record the
   // expected word if a transfer is due, then advance past the next edge.
   task automatic cyc4(input logic [3:0] rdy, input logic ov, input logic push,
                       input logic [1:0] ch, input logic [15:0] d);
      @(negedge clk);
      chk("in_ready4", 32'(bus4.in_ready), 32'(rdy));
      chk("out_valid4", 32'(bus4.out_valid), 32'(ov));
      if (push) q4.push_back({ch, d});
      @(posedge clk);
      #1;
   endtask

   task automatic cyc3(input logic [2:0] rdy, input logic ov, input logic push,
                       input logic [1:0] ch, input logic [15:0] d);
      @(negedge clk);
      chk("in_ready3", 32'(bus3.in_ready), 32'(rdy));
      chk("out_valid3", 32'(bus3.out_valid), 32'(ov));
      if (push) q3.push_back({ch, d});
      @(posedge clk);
      #1;
   endtask

   // Output monitors: a word is consumed at the edge following a negedge
   // where valid and ready are both high.
   always @(negedge clk) begin
      if (bus4.out_valid && bus4.out_ready) begin
         if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb4_unexpected actual ch=%0d data=%h required none",
                     bus4.out_ch, bus4.out_data);
         end else begin
            exp4 = q4.pop_front();
            chk("sb4_word", {14'd0, bus4.out_ch, bus4.out_data}, {14'd0, exp4});
            $display("dut4 word ch=%0d data=%h expected ch=%0d data=%h",
                     bus4.out_ch, bus4.out_data, exp4[17:16], exp4[15:0]);
         end
      end
   end

   always @(negedge clk) begin
      if (bus3.out_valid && bus3.out_ready) begin
         if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb3_unexpected actual ch=%0d data=%h required none",
                     bus3.out_ch, bus3.out_data);
         end else begin
            exp3 = q3.pop_front();
            chk("sb3_word", {14'd0, bus3.out_ch, bus3.out_data}, {14'd0, exp3});
            $display("dut3 word ch=%0d data=%h expected ch=%0d data=%h",
                     bus3.out_ch, bus3.out_data, exp3[17:16], exp3[15:0]);
         end
      end
   end

   initial begin
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      bus4.mode      = MODE_SEL;
      bus4.sel       = 2'd0;
      bus4.out_ready = 1'b1;
      set4(4'b1111, 16'h1000, 16'h1001, 16'h1002, 16'h1003);
      bus3.mode      = MODE_SEL;
      bus3.sel       = 2'd0;
      bus3.out_ready = 1'b1;
      bus3.in_valid  = 3'b000;
      bus3.in_data   = '0;
      #1;
      rst_n  = 1'b0;
      rst3_n = 1'b0;

      // 1. Reset with every channel valid.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("rst_out_data", 32'(bus4.out_data), 32'd0);
      chk("rst_out_ch", 32'(bus4.out_ch), 32'd0);
      chk("rst_in_ready", 32'(bus4.in_ready), 32'd0);
      chk("rst3_in_ready", 32'(bus3.in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      rst3_n = 1'b1;
      cyc4(4'b0001, 1'b0, 1'b1, 2'd0, 16'h1000);
      set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc4(4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);

      // 2. Select mode, sel=2, all-ones data.
      bus4.sel = 2'd2;
      set4(4'b0100, 16'h0, 16'h0, 16'hFFFF, 16'h0);
      cyc4(4'b0100, 1'b0, 1'b1, 2'd2, 16'hFFFF);
      set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc4(4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);

      // 3. Stall: held word must survive sel/data changes.
      set4(4'b0100, 16'h0, 16'h0, 16'h2222, 16'h0);
      cyc4(4'b0100, 1'b0, 1'b1, 2'd2, 16'h2222);
      bus4.out_ready = 1'b0;
      bus4.sel       = 2'd1;
      set4(4'b1111, 16'h0001, 16'h5A5A, 16'h0003, 16'h0004);
      for (int k = 0; k < 3; k++) begin
         cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
         chk("stall_out_data", 32'(bus4.out_data), 32'h2222);
         chk("stall_out_ch", 32'(bus4.out_ch), 32'd2);
      end
      bus4.out_ready = 1'b1;
      cyc4(4'b0010, 1'b1, 1'b1, 2'd1, 16'h5A5A);
      set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc4(4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);

      // 4. Round-robin with every channel valid: 0,1,2,3,0,1 back to back.
      bus4.mode = MODE_RR;
      set4(4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
      for (int k = 0; k < 6; k++) begin
         cyc4(4'(1 << (k % 4)), (k != 0), 1'b1, 2'(k % 4), 16'hA000 + 16'(k % 4));
      end
      set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc4(4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);

      // 5. Pointer now 2; only ch1 and ch3 requesting -> 3 then 1.
      set4(4'b1010, 16'h0, 16'h0001, 16'h0, 16'h0003);
      cyc4(4'b1000, 1'b0, 1'b1, 2'd3, 16'h0003);
      cyc4(4'b0010, 1'b1, 1'b1, 2'd1, 16'h0001);
      set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc4(4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);

      // Select-mode transfer must not move the pointer (still 2).
      bus4.mode = MODE_SEL;
      bus4.sel  = 2'd0;
      set4(4'b0001, 16'hB000, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0001, 1'b0, 1'b1, 2'd0, 16'hB000);
      bus4.mode = MODE_RR;
      set4(4'b1111, 16'hC000, 16'hC001, 16'hC002, 16'hC003);
      cyc4(4'b0100, 1'b1, 1'b1, 2'd2, 16'hC002);
      set4(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0);
      cyc4(4'b0000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc4(4'b0000, 1'b0, 1'b0, 2'd0, 16'h0);

      // 6. NUM_CH=3: out-of-range select, then async reset mid-stall.
      bus3.sel      = 2'd1;
      bus3.in_valid = 3'b010;
      bus3.in_data  = {16'h0CC2, 16'h0BB1, 16'h0AA0};
      cyc3(3'b010, 1'b0, 1'b1, 2'd1, 16'h0BB1);
      bus3.sel      = 2'd3;
      bus3.in_valid = 3'b111;
      cyc3(3'b000, 1'b1, 1'b0, 2'd0, 16'h0);
      cyc3(3'b000, 1'b0, 1'b0, 2'd0, 16'h0);
      chk("sel3_hold_data", 32'(bus3.out_data), 32'h0BB1);
      chk("sel3_hold_ch", 32'(bus3.out_ch), 32'd1);
      bus3.out_ready = 1'b0;
      bus3.sel       = 2'd2;
      cyc3(3'b100, 1'b0, 1'b0, 2'd0, 16'h0);
      @(negedge clk);
      chk("stall3_out_valid", 32'(bus3.out_valid), 32'd1);
      chk("stall3_out_data", 32'(bus3.out_data), 32'h0CC2);
      chk("stall3_in_ready", 32'(bus3.in_ready), 32'd0);
      #2;
      rst3_n   = 1'b0;
      bus3.sel = 2'd3;
      #1;
      chk("arst3_out_valid", 32'(bus3.out_valid), 32'd0);
      chk("arst3_out_data", 32'(bus3.out_data), 32'd0);
      chk("arst3_out_ch", 32'(bus3.out_ch), 32'd0);
      chk("arst3_in_ready", 32'(bus3.in_ready), 32'd0);
      #1;
      rst3_n = 1'b1;
      @(posedge clk);
      #1;
      cyc3(3'b000, 1'b0, 1'b0, 2'd0, 16'h0);

      repeat (2) @(posedge clk);
      chk("q4_drained", 32'(q4.size()), 32'd0);
      chk("q3_drained", 32'(q3.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
